// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared state encoding and sizing helpers for the sequential add/sub engine
package seq_addsub_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational ripple-carry slice exposing the carry into its top bit
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;
  // ripple the carry bit by bit through the slice
  always_comb begin
    c = '0;
    sum = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/seq_addsub_responder.sv
// seq_addsub_responder: multi-cycle chunked add/subtract engine behind valid/ready request and response ports
module seq_addsub_responder
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW = idx_w(NCHUNK);
  state_t state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry_r;
  logic [CHUNK-1:0] s;
  logic co, cm;
  // operands shift right each CALC cycle so chunk idx always sits in the low bits
  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a(a_r[CHUNK-1:0]),
    .b(b_r[CHUNK-1:0]),
    .cin(carry_r),
    .sum(s),
    .cout(co),
    .c_msb_in(cm)
  );
  assign req_ready = state == IDLE;
  assign rsp_valid = state == DONE;
  // control FSM with operand, carry and result registers; result fills from the top as chunks arrive
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      carry_r <= 1'b0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_r <= req_a;
          b_r <= req_sub ? ~req_b : req_b;
          carry_r <= req_sub | req_cin;
          idx <= '0;
          rsp_sum <= '0;
          rsp_cout <= 1'b0;
          rsp_ovf <= 1'b0;
          state <= CALC;
        end
        CALC: begin
          a_r <= a_r >> CHUNK;
          b_r <= b_r >> CHUNK;
          carry_r <= co;
          rsp_sum <= {s, rsp_sum[WIDTH-1:CHUNK]};
          idx <= idx + 1'b1;
          if (idx == IW'(NCHUNK - 1)) begin
            rsp_cout <= co;
            rsp_ovf <= cm ^ co;
            state <= DONE;
          end
        end
        DONE: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_addsub_responder.sv
// tb_seq_addsub_responder: directed scoreboard bench for the sequential add/sub engine
module tb_seq_addsub_responder;
  localparam int W = 32;
  localparam int NCH = 8;
  typedef struct packed {
    logic [W-1:0] sum;
    logic cout;
    logic ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_cin, req_sub, rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
  logic [W-1:0] req_a, req_b, rsp_sum;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  seq_addsub_responder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0] full;
    exp_t e;
    bb = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub ? 1'b1 : cin};
    e.sum = full[W-1:0];
    e.cout = full[W];
    e.ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_cin = cin;
    req_sub = sub;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept_bound", 64'(n < 50), 64'd1);
    @(posedge clk);
    sb.push_back(model(a, b, cin, sub));
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!rsp_valid && lat < 100);
    chk("latency", 64'(lat), 64'(NCH));
  endtask
  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("sum", 64'(rsp_sum), 64'(e.sum));
    chk("cout", 64'(rsp_cout), 64'(e.cout));
    chk("ovf", 64'(rsp_ovf), 64'(e.ovf));
  endtask
  task automatic recv_ack();
    int lat;
    wait_valid(lat);
    compare();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_ack_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_ack_req_ready", 64'(req_ready), 64'd1);
  endtask
  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    send(a, b, cin, sub);
    recv_ack();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    int lat, seen;
    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_cin = 1'b0;
    req_sub = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_sum", 64'(rsp_sum), 64'd0);
    chk("reset_cout", 64'(rsp_cout), 64'd0);
    chk("reset_ovf", 64'(rsp_ovf), 64'd0);
    run(32'h00000002, 32'h00000002, 1'b0, 1'b0);
    run(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run(32'h00000006, 32'h00000003, 1'b1, 1'b1);
    run(32'h00000003, 32'h00000008, 1'b1, 1'b1);
    run(32'h99999999, 32'h99999999, 1'b1, 1'b0);
    run(32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0);
    run(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    send(32'h0F0F1234, 32'h01011111, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    recv_ack();
    send(32'h00001234, 32'h00001111, 1'b0, 1'b0);
    wait_valid(lat);
    req_valid = 1'b1;
    req_a = 32'h00000100;
    req_b = 32'h00000200;
    req_cin = 1'b0;
    req_sub = 1'b0;
    e = sb[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_sum", 64'(rsp_sum), 64'(e.sum));
      chk("stall_cout", 64'(rsp_cout), 64'(e.cout));
      chk("stall_ovf", 64'(rsp_ovf), 64'(e.ovf));
    end
    compare();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("no_accept_on_rsp_edge", 64'(req_ready), 64'd1);
    chk("rsp_dropped_after_ack", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    sb.push_back(model(32'h00000100, 32'h00000200, 1'b0, 1'b0));
    @(negedge clk);
    req_valid = 1'b0;
    chk("held_req_accepted", 64'(req_ready), 64'd0);
    recv_ack();
    send(32'h0000AAAA, 32'h00005555, 1'b0, 1'b0);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_req_ready", 64'(req_ready), 64'd1);
    chk("midreset_sum", 64'(rsp_sum), 64'd0);
    chk("midreset_cout", 64'(rsp_cout), 64'd0);
    chk("midreset_ovf", 64'(rsp_ovf), 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("midreset_no_response", 64'(seen), 64'd0);
    run(32'h00006758, 32'h00003241, 1'b0, 1'b0);
    chk("final_sum_9999", 64'(rsp_sum), 64'h9999);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_addsub_responder.md
Name: seq_addsub_responder

Overview:
- Multi-cycle add/subtract engine that serves operation requests over a valid/ready interface and returns results over a second valid/ready interface.
- Acts as the responder to an operation initiator (stimulus generator, ALU sequencer, or test harness).
- Adds or subtracts WIDTH-bit operands, CHUNK bits per clock, through a chunk ripple-carry datapath.
- Reports sum, carry-out and signed overflow, giving a small-area sequential counterpart to the combinational RCA/CLA/PPA/KSA adders.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per CALC cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_cin  in  1  carry-in; used for add only.
- req_sub  in  1  1 = A-B, 0 = A+B+cin.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes result.
- rsp_sum  out  WIDTH  result.
- rsp_cout  out  1  carry-out; for sub, 1 = no borrow.
- rsp_ovf  out  1  two's-complement overflow.

Behaviour:
- Reset and clocking: one clock, clk. Reset rst is synchronous and active-high. A reset edge forces state IDLE and zeroes the chunk counter and the operand/result registers. After the reset edge: req_ready=1, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
- Reset mid-operation (CALC or DONE): the operation is abandoned with no response emitted. The next cycle shows IDLE values.
- States: IDLE, CALC, DONE.
  - req_ready=1 only in IDLE.
  - rsp_valid=1 only in DONE.
  - Both are decoded from the state register, glitch-free.
- IDLE:
  - On an edge with req_valid=1, latch req_a into a_r.
  - Latch b_r = req_sub ? ~req_b : req_b.
  - Latch carry_r = req_sub ? 1 : req_cin.
  - Clear idx and result; go to CALC.
  - req_* inputs are ignored on any edge without a handshake.
- CALC:
  - Each edge adds chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) of a_r, b_r and carry_r.
  - Writes the CHUNK sum bits into the result register and updates carry_r; idx increments.
  - On the edge where idx == NCHUNK-1:
    - rsp_cout = chunk carry-out.
    - rsp_ovf = carry into MSB XOR carry out of MSB.
    - Go to DONE.
- Latency: rsp_valid asserts after exactly NCHUNK edges following the accept edge (8 for 32/4). Throughput is one operation per NCHUNK+2 cycles at best.
- DONE:
  - rsp_sum, rsp_cout and rsp_ovf are stable while rsp_valid=1.
  - On an edge with rsp_ready=1, go to IDLE.
  - No request is accepted in the same cycle as the response handshake; req_ready rises the cycle after.
- Width rules: sum is modulo 2^WIDTH.
  - Subtraction is A + ~B + 1, and req_cin is ignored.
  - Carries never escape the chunk boundary except through carry_r.
- Boundary handling:
  - rsp_ready held low indefinitely → stall in DONE, outputs frozen.
  - rsp_ready high before DONE → no effect.
  - idx wraps only through the return to IDLE.

Decomposition:
- Package seq_addsub_pkg:
  - state_t enum {IDLE, CALC, DONE}.
  - Function clog2-based width for idx.
  - localparam helper for NCHUNK.
- Sub-module chunk_adder: parameter CHUNK. Inputs a, b, cin. Outputs sum, cout, c_msb_in (carry into top bit, for overflow). Pure combinational ripple-carry.
- Top module holds the FSM, counter, operand and result registers.

Test Plan:
- Add 0x00000002+0x00000002, cin=0 → sum 0x00000004, cout 0, ovf 0. rsp_valid exactly 8 edges after accept.
- Add 0xFFFFFFFF+0x00000001 → sum 0x00000000, cout 1, ovf 0. Add 0x7FFFFFFF+0x00000001 → 0x80000000, cout 0, ovf 1.
- Sub 0x00000006-0x00000003 → 0x00000003, cout 1, ovf 0. Sub 0x00000003-0x00000008 → 0xFFFFFFFB, cout 0, ovf 0. In both, req_cin=1 has no effect.
- Add 0x99999999+0x99999999, cin=1 → 0x33333333, cout 1, ovf 1. Add 0xDEADBEEF+0x00000000, cin=1 → 0xDEADBEF0, cout 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → sum, cout and ovf unchanged, req_ready=0. A request held valid throughout is accepted only on the first edge after the rsp handshake.
- Assert rst during CALC at idx=3 → next cycle rsp_valid=0, req_ready=1, outputs 0, no response emitted. The following op 0x6758+0x3241 (zero-extended) returns 0x00009999.
